icache_refill: RTL and testbench

Refill engine between the instruction cache's memory-side port and the 32-bit instruction memory bus. On a cache miss it fetches a `BLOCK_SIZE`-word block one word at a time, critical word first with wrap-around, assembles the block, and returns it with a one-cycle ready pulse. The cache-side ports mirror the cache's refill interface, so the cache connects without glue logic.

---
 rtl/icache_refill.sv | 96 +++++++++
 tb/tb_icache_refill.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: fetches a block one word at a time, critical word first,
// wrapping inside the block, and hands the assembled block back with a one-cycle ready pulse.
module icache_refill #(
    parameter int unsigned BLOCK_SIZE = 1,
    parameter int unsigned XLEN       = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_DataReq,
    input  logic [XLEN-1:0]          i_MemAddr,
    output logic [BLOCK_SIZE*32-1:0] o_DataBlock,
    output logic                     o_MemReady,
    output logic                     o_MemRd,
    output logic [XLEN-1:0]          o_MemRdAddr,
    input  logic                     i_MemAck,
    input  logic [31:0]              i_MemRdData,
    output logic                     o_Busy
);

    localparam int unsigned M  = $clog2(BLOCK_SIZE);
    localparam int unsigned OW = (M > 0) ? M : 1;

    localparam logic [XLEN-1:0] OFF_MASK  = XLEN'(BLOCK_SIZE * 4 - 1);
    localparam logic [OW-1:0]   SLOT_MASK = OW'(BLOCK_SIZE - 1);
    localparam logic [OW-1:0]   LAST      = OW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e                  state;
    logic [XLEN-1:0]         base;
    logic [OW-1:0]           start;
    logic [OW-1:0]           count;
    logic [XLEN-1:0]         rd_addr;
    logic [BLOCK_SIZE*32-1:0] block;

    logic [XLEN-1:0] req_base;
    logic [OW-1:0]   req_start;
    logic [OW-1:0]   slot;
    logic [OW-1:0]   next_slot;

    // Masking with SLOT_MASK keeps the offset inside the block (and at 0 when BLOCK_SIZE=1).
    always_comb begin
        req_base  = i_MemAddr & ~OFF_MASK;
        req_start = OW'(i_MemAddr >> 2) & SLOT_MASK;
        slot      = (start + count) & SLOT_MASK;
        next_slot = (start + count + 1'b1) & SLOT_MASK;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= StIdle;
            base    <= '0;
            start   <= '0;
            count   <= '0;
            rd_addr <= '0;
            block   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_DataReq) begin
                        base    <= req_base;
                        start   <= req_start;
                        count   <= '0;
                        rd_addr <= req_base | (XLEN'(req_start) << 2);
                        state   <= StFetch;
                    end
                end
                StFetch: begin
                    if (i_MemAck) begin
                        block[32*int'(slot) +: 32] <= i_MemRdData;
                        count   <= count + 1'b1;
                        rd_addr <= base | (XLEN'(next_slot) << 2);
                        if (count == LAST) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_MemRd     = (state == StFetch);
        o_MemReady  = (state == StDone);
        o_Busy      = (state != StIdle);
        o_MemRdAddr = rd_addr;
        o_DataBlock = block;
    end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: a 4-word and a 1-word instance driven by directed and random refills,
// checked against a slot-array model of the block and the wrap-around address sequence.
module tb_icache_refill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         req4, rdy4, rd4, ack4, busy4;
    logic [31:0]  addr4, rdaddr4, rdata4;
    logic [127:0] blk4;

    logic         req1, rdy1, rd1, ack1, busy1;
    logic [31:0]  addr1, rdaddr1, rdata1;
    logic [31:0]  blk1;

    icache_refill #(.BLOCK_SIZE(4), .XLEN(32)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_DataReq(req4), .i_MemAddr(addr4),
        .o_DataBlock(blk4), .o_MemReady(rdy4), .o_MemRd(rd4), .o_MemRdAddr(rdaddr4),
        .i_MemAck(ack4), .i_MemRdData(rdata4), .o_Busy(busy4)
    );

    icache_refill #(.BLOCK_SIZE(1), .XLEN(32)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_DataReq(req1), .i_MemAddr(addr1),
        .o_DataBlock(blk1), .o_MemReady(rdy1), .o_MemRd(rd1), .o_MemRdAddr(rdaddr1),
        .i_MemAck(ack1), .i_MemRdData(rdata1), .o_Busy(busy1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model4 [4];
    logic [31:0] model1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_block4();
        return {model4[3], model4[2], model4[1], model4[0]};
    endfunction

    task automatic chk_idle4(input string tag);
        chk({tag, "_rd"}, 128'(rd4), 128'(0));
        chk({tag, "_ready"}, 128'(rdy4), 128'(0));
        chk({tag, "_busy"}, 128'(busy4), 128'(0));
    endtask

    // Entered at the falling edge of the first FETCH cycle; returns at the falling edge of DONE.
    task automatic fetch4(input logic [31:0] a, input int minw, input int maxw, input bit disturb);
        logic [31:0] b;
        int          st;
        b  = a & ~32'hF;
        st = int'((a >> 2) % 4);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ea;
            logic [31:0] d;
            int          w;
            ea = b + 32'(((st + k) % 4) * 4);
            w  = int'($urandom_range(maxw, minw));
            for (int j = 0; j < w; j++) begin
                chk("wait_rd", 128'(rd4), 128'(1));
                chk("wait_addr", 128'(rdaddr4), 128'(ea));
                chk("wait_ready", 128'(rdy4), 128'(0));
                ack4 = 1'b0;
                @(negedge clk);
            end
            chk("fetch_rd", 128'(rd4), 128'(1));
            chk("fetch_addr", 128'(rdaddr4), 128'(ea));
            chk("fetch_busy", 128'(busy4), 128'(1));
            d      = $urandom;
            ack4   = 1'b1;
            rdata4 = d;
            model4[(st + k) % 4] = d;
            if (disturb && k == 1) begin
                req4  = 1'b0;
                addr4 = $urandom & ~32'h3;
            end
            @(negedge clk);
            ack4   = 1'b0;
            rdata4 = $urandom;
        end
        chk("done_ready", 128'(rdy4), 128'(1));
        chk("done_rd", 128'(rd4), 128'(0));
        chk("done_busy", 128'(busy4), 128'(1));
        chk("done_block", blk4, exp_block4());
    endtask

    task automatic refill4(input logic [31:0] a, input int minw, input int maxw);
        req4  = 1'b1;
        addr4 = a;
        @(negedge clk);
        fetch4(a, minw, maxw, 1'b0);
        req4 = 1'b0;
        @(negedge clk);
        chk_idle4("after_done");
    endtask

    task automatic refill1(input logic [31:0] a, input logic [31:0] d, input int maxw);
        int w;
        req1  = 1'b1;
        addr1 = a;
        @(negedge clk);
        w = int'($urandom_range(maxw, 0));
        for (int j = 0; j <= w; j++) begin
            chk("b1_rd", 128'(rd1), 128'(1));
            chk("b1_addr", 128'(rdaddr1), 128'(a));
            chk("b1_ready", 128'(rdy1), 128'(0));
            if (j == w) begin
                ack1   = 1'b1;
                rdata1 = d;
            end
            @(negedge clk);
        end
        model1 = d;
        ack1   = 1'b0;
        req1   = 1'b0;
        chk("b1_done_ready", 128'(rdy1), 128'(1));
        chk("b1_done_rd", 128'(rd1), 128'(0));
        chk("b1_done_block", 128'(blk1), 128'(model1));
        @(negedge clk);
        chk("b1_idle_ready", 128'(rdy1), 128'(0));
        chk("b1_idle_busy", 128'(busy1), 128'(0));
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        req4 = 1'b0; addr4 = '0; ack4 = 1'b0; rdata4 = '0;
        req1 = 1'b0; addr1 = '0; ack1 = 1'b0; rdata1 = '0;
        for (int i = 0; i < 4; i++) model4[i] = '0;
        model1 = '0;
        #1 rst = 1'b0;
        #1;
        chk_idle4("reset");
        chk("reset_addr", 128'(rdaddr4), 128'(0));
        chk("reset_block", blk4, 128'(0));
        chk("reset_b1_block", 128'(blk1), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // One-word block, zero-wait, then a few random ones.
        refill1(32'h0000_0104, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 3; i++) refill1($urandom & ~32'h3, $urandom, 2);

        // Critical word at slot 2, wraps to 0x200/0x204.
        refill4(32'h0000_0208, 0, 0);

        // Two wait cycles per word: ready lands 13 cycles after the request.
        refill4($urandom & ~32'h3, 2, 2);

        // Request held across DONE: one IDLE cycle, then a new refill at 0x300.
        req4  = 1'b1;
        addr4 = $urandom & ~32'h3;
        @(negedge clk);
        fetch4(addr4, 0, 1, 1'b0);
        addr4 = 32'h0000_0300;
        @(negedge clk);
        chk_idle4("held_req_gap");
        @(negedge clk);
        fetch4(32'h0000_0300, 0, 1, 1'b0);
        req4 = 1'b0;
        @(negedge clk);
        chk_idle4("held_req_end");

        // Request dropped and address changed mid-refill: original block still completes.
        a     = $urandom & ~32'h3;
        req4  = 1'b1;
        addr4 = a;
        @(negedge clk);
        fetch4(a, 0, 1, 1'b1);
        req4 = 1'b0;
        @(negedge clk);
        chk_idle4("disturb_end");

        // Asynchronous reset after two of four words.
        req4  = 1'b1;
        addr4 = 32'h0000_0408;
        @(negedge clk);
        req4 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ack4   = 1'b1;
            rdata4 = $urandom;
            @(negedge clk);
        end
        ack4 = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_idle4("async_reset");
        chk("async_reset_addr", 128'(rdaddr4), 128'(0));
        chk("async_reset_block", blk4, 128'(0));
        chk("async_reset_b1_block", 128'(blk1), 128'(0));
        for (int i = 0; i < 4; i++) model4[i] = '0;
        ack4 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle4("late_ack");
        chk("late_ack_block", blk4, 128'(0));
        ack4 = 1'b0;
        refill4(32'h0000_0408, 0, 1);

        // Random refills with random wait states.
        for (int i = 0; i < 8; i++) refill4($urandom & ~32'h3, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
